// File: rtl/calc_hs_master.sv
// Initiator for the ap_ctrl_hs handshake. Takes operand pairs in, runs one core
// operation at a time, and buffers the returned values in a small result FIFO.
module calc_hs_master #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              core_start,
    output logic [DATA_W-1:0] core_a,
    output logic [DATA_W-1:0] core_b,
    input  logic              core_done,
    input  logic              core_ready,
    input  logic              core_idle,
    input  logic [DATA_W-1:0] core_return,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err_timeout,
    output logic [15:0]       op_count
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_core_a, r_core_b;
    logic [15:0]       r_tmo_cnt;
    logic              r_err;
    logic [15:0]       r_op_cnt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [CW-1:0]     r_count;

    logic              w_accept, w_push, w_pop, w_abort, w_last, w_busy;
    logic [CW-1:0]     w_count_nxt;
    logic              w_unused;

    assign w_unused   = core_idle;
    assign w_busy     = (r_state != S_IDLE);
    assign w_accept   = in_valid && r_in_ready && (r_state == S_IDLE);
    // Saturating counter plus >= keeps the abort reachable even if done was held off.
    assign w_last     = (r_tmo_cnt >= 16'(TIMEOUT - 1));
    assign out_valid  = (r_count != '0);
    assign w_pop      = out_valid && out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (core_ready && core_done) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_last && !core_done) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (core_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_done) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_last) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state    <= S_IDLE;
            r_core_a   <= '0;
            r_core_b   <= '0;
            r_tmo_cnt  <= '0;
            r_err      <= 1'b0;
            r_op_cnt   <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_core_a  <= in_a;
                r_core_b  <= in_b;
                r_tmo_cnt <= '0;
            end else if (w_busy && r_tmo_cnt != 16'hFFFF) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
            if (w_abort) r_err <= 1'b1;
            if (w_push)  r_op_cnt <= r_op_cnt + 16'd1;
            // Registered credit: next-cycle state and occupancy decide acceptance.
            r_in_ready <= (w_state_nxt == S_IDLE) && (w_count_nxt < CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= core_return;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
        end
    end

    assign in_ready    = r_in_ready;
    assign core_start  = (r_state == S_ISSUE);
    assign core_a      = r_core_a;
    assign core_b      = r_core_b;
    assign out_data    = r_mem[r_rptr];
    assign err_timeout = r_err;
    assign op_count    = r_op_cnt;

endmodule

// File: doc/calc_hs_master.md
Name: calc_hs_master

Overview:
- Initiator side of the ap_ctrl_hs block-level handshake used by the calculate_* cores.
- Accepts operand pairs on a valid/ready stream and issues each pair to one attached calculate core via ap_start.
- Captures the core's return value into a small output FIFO and presents results on a valid/ready stream.
- Tolerates both combinational cores (done in the same cycle as start) and multi-cycle cores, with a done-timeout guard.

Parameters:
- DATA_W, 32, operand and result width.
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.
- TIMEOUT, 255, cycles allowed in ISSUE+WAIT before abort; 1..65535.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid && in_ready.
- in_a  in  DATA_W  operand a.
- in_b  in  DATA_W  operand b.
- core_start  out  1  drives core ap_start.
- core_a  out  DATA_W  drives core a.
- core_b  out  DATA_W  drives core b.
- core_done  in  1  core ap_done.
- core_ready  in  1  core ap_ready.
- core_idle  in  1  core ap_idle; status only, not used for sequencing.
- core_return  in  DATA_W  core ap_return.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  DATA_W  FIFO head.
- err_timeout  out  1  sticky; set on abort.
- op_count  out  16  completed ops; wraps at 65535 -> 0.

Behaviour:
- Reset is asynchronous, active-low ap_rst_n, single clock ap_clk. On assertion, immediately:
  - state=IDLE;
  - core_start=0, in_ready=0, out_valid=0;
  - core_a=core_b=0, out_data=0;
  - FIFO empty, err_timeout=0, op_count=0, timeout counter=0.
- Reset mid-operation abandons the in-flight op with no result pushed.
- Credit rule: in_ready=1 only in IDLE and only when fifo_count < FIFO_DEPTH. A push can therefore never hit a full FIFO.
- IDLE:
  - On in_valid && in_ready, register in_a/in_b into core_a/core_b, clear the timeout counter, go ISSUE.
  - core_a/core_b hold their values until the next accept.
- ISSUE: core_start=1.
  - core_ready && core_done: push core_return, go IDLE.
  - core_ready && !core_done: go WAIT.
  - Otherwise stay.
- WAIT: core_start=0.
  - On core_done, push core_return and go IDLE.
- Timeout:
  - The counter increments each cycle in ISSUE or WAIT.
  - If it reaches TIMEOUT without core_done: set err_timeout, push nothing, core_start=0, go IDLE.
  - core_done arriving on the same cycle as the timeout counts as completion; no error.
- Push increments op_count; 16-bit wrap.
- Latency with a combinational core:
  - accept at cycle N;
  - core_start high in N+1, result pushed at the end of N+1;
  - out_valid high from N+2.
  - Max throughput is one op per 2 cycles.
- FIFO:
  - out_data is the registered head; no bypass, so a push into an empty FIFO is visible the following cycle.
  - Simultaneous push and pop when non-empty: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Results are the raw DATA_W core_return; no sign or width manipulation.
- err_timeout clears only on reset.

Test Plan:
- calculate_4 attached, a=5, b=7, out_ready=1 -> out_data=105 two cycles after accept; op_count=1.
- a=950, b=3 -> 1053 (value 1050 > 1000 path).
- a=0xFFFFFF9C, b=9 -> out_data=0x00000000 (wrap to 0, not > 1000).
- a=0x7FFFFFFF, b=1 -> 0x80000063 (signed compare negative).
- out_ready=0, push 6 ops, FIFO_DEPTH=4 -> in_ready low after 4th push; out_data sequence preserved once out_ready=1; op_count=6.
- Multi-cycle stub core:
  - done 3 cycles after ready -> correct capture;
  - never-done stub with TIMEOUT=10 -> err_timeout=1 at 10th cycle, no push, back to IDLE.
- Reset mid-operation: ap_rst_n=0 asserted in WAIT -> core_start=0 immediately, FIFO empty, op_count=0.
